platform_scroller: RTL and testbench

Owns the 16 platform slots of the playfield. Consumes the per-frame scroll displacement and scroll enable from the doodle physics stage and produces the `platX*/platY*` coordinates that the physics stage uses for collision and the renderer draws. On each frame it shifts every platform down by the scroll amount. Platforms that fall off the bottom are respawned at the top with a pseudo-random X.

---
 rtl/platform_scroller.sv | 118 +++++++++++
 tb/tb_platform_scroller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/platform_scroller.sv
// platform_scroller: owns 16 platform slots, scrolls them down per frame and respawns the ones that fall off
// Ports: Clk/Reset_n (async active-low); frame_clk frame tick (synchronised, rise-detected);
//   loadplat requests the initial layout; refresh_en + plat_temp_Y (signed, negative = rising) request a scroll;
//   plat_x_flat/plat_y_flat 9 bits per slot; busy during a walk; update_done pulses when a walk completes;
//   score accumulated scroll distance.
// Optional feature: define PLAT_SCORE_EN to build the score accumulator (otherwise score is 0).
module platform_scroller #(
  parameter int NUM_PLAT = 16,
  parameter int SCREEN_Y_MAX = 479,
  parameter int Y_SPAN = 480,
  parameter int X_MIN = 32,
  parameter int X_MAX = 480,
  parameter int MAX_STEP = 15,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_clk,
  input  logic         loadplat,
  input  logic         refresh_en,
  input  logic [9:0]   plat_temp_Y,
  output logic [143:0] plat_x_flat,
  output logic [143:0] plat_y_flat,
  output logic         busy,
  output logic         update_done,
  output logic [15:0]  score
);
  typedef enum logic [1:0] {IDLE, INIT, SCROLL} state_t;
  localparam logic [15:0] SEED_R = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [8:0] RNG = 9'(X_MAX - X_MIN);
  state_t state_q, state_d;
  logic [2:0] sync_q;
  logic fe_q, done_q, walk_end, start_scroll;
  logic [3:0] idx_q, amt_q, amt_c;
  logic [15:0] lfsr_q;
  logic [8:0] x_q [NUM_PLAT];
  logic [8:0] y_q [NUM_PLAT];
  logic [9:0] neg_c, ny_c;
  logic [8:0] c_c, rx_c, iy_c;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // loadplat wins from any state: starts INIT, aborts SCROLL, restarts INIT
  always_comb begin
    state_d = state_q;
    if (loadplat) state_d = INIT;
    else if (state_q == IDLE) state_d = (fe_q && refresh_en && plat_temp_Y[9]) ? SCROLL : IDLE;
    else if (idx_q == 4'd15) state_d = IDLE;
  end

  always_comb begin
    busy = state_q != IDLE;
    walk_end = busy && !loadplat && idx_q == 4'd15;
    start_scroll = state_q == IDLE && state_d == SCROLL;
    update_done = done_q;
  end

  always_comb begin
    neg_c = -plat_temp_Y;
    amt_c = (neg_c > 10'(MAX_STEP)) ? 4'(MAX_STEP) : neg_c[3:0];
    c_c = lfsr_q[8:0];
    // fold values beyond the span back into range instead of rejecting them
    rx_c = 9'(X_MIN) + ((c_c > RNG) ? c_c - RNG - 9'd1 : c_c);
    ny_c = {1'b0, y_q[idx_q]} + {6'd0, amt_q};
    iy_c = 9'd15 + 9'(idx_q) * 9'd30;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      fe_q <= 1'b0;
      lfsr_q <= SEED_R;
      idx_q <= '0;
      amt_q <= '0;
      done_q <= 1'b0;
      for (int k = 0; k < NUM_PLAT; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      // two synchroniser flops plus one history flop; the edge itself is registered too
      sync_q <= {sync_q[1:0], frame_clk};
      fe_q <= sync_q[1] & ~sync_q[2];
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      idx_q <= (!busy || loadplat) ? 4'd0 : idx_q + 4'd1;
      done_q <= walk_end;
      if (start_scroll) amt_q <= amt_c;
      if (busy && !loadplat) begin
        if (state_q == INIT) begin
          y_q[idx_q] <= iy_c;
          x_q[idx_q] <= rx_c;
        end else if (ny_c > 10'(SCREEN_Y_MAX)) begin
          y_q[idx_q] <= 9'(ny_c - 10'(Y_SPAN));
          x_q[idx_q] <= rx_c;
        end else y_q[idx_q] <= ny_c[8:0];
      end
    end
  end

`ifdef PLAT_SCORE_EN
  logic [15:0] score_q;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) score_q <= '0;
    else if (start_scroll) score_q <= score_q + {12'd0, amt_c};
  end
  assign score = score_q;
`else
  assign score = 16'd0;
`endif

  for (genvar i = 0; i < NUM_PLAT; i++) begin : g_pack
    assign plat_x_flat[9*i +: 9] = x_q[i];
    assign plat_y_flat[9*i +: 9] = y_q[i];
  end
endmodule

// File: tb/tb_platform_scroller.sv
// tb_platform_scroller: directed self-checking bench for platform_scroller
module tb_platform_scroller;
  logic Clk = 0, Reset_n = 0, frame_clk = 0, loadplat = 0, refresh_en = 0;
  logic [9:0] plat_temp_Y = '0;
  logic [143:0] plat_x_flat, plat_y_flat;
  logic busy, update_done;
  logic [15:0] score;
  int checks = 0, errors = 0;
  int b, d, d1, exp_score = 0;
  logic [8:0] snap_x [16];

  platform_scroller dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .loadplat(loadplat),
    .refresh_en(refresh_en), .plat_temp_Y(plat_temp_Y), .plat_x_flat(plat_x_flat),
    .plat_y_flat(plat_y_flat), .busy(busy), .update_done(update_done), .score(score)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sc(input int v);
`ifdef PLAT_SCORE_EN
    return 32'(v % 65536);
`else
    return 32'(0 * v);
`endif
  endfunction

  function automatic logic [8:0] py(input int i);
    return plat_y_flat[9*i +: 9];
  endfunction

  function automatic logic [8:0] px(input int i);
    return plat_x_flat[9*i +: 9];
  endfunction

  task automatic walk(input int n, output int bc, output int dc);
    bc = 0;
    dc = 0;
    for (int k = 0; k < n; k++) begin
      if (busy) bc++;
      if (update_done) dc++;
      @(negedge Clk);
    end
  endtask

  task automatic wait_busy;
    int k = 0;
    while (!busy && k < 20) begin
      @(negedge Clk);
      k++;
    end
    check("busy_wait", 32'(busy), 1);
  endtask

  task automatic frame_rise(input logic [9:0] ty, input logic en);
    frame_clk = 0;
    repeat (4) @(negedge Clk);
    plat_temp_Y = ty;
    refresh_en = en;
    frame_clk = 1;
  endtask

  task automatic check_init_layout(input string tag);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_y"}, 32'(py(i)), 32'(15 + 30 * i));
      check({tag, "_xrange"}, 32'(px(i) >= 32 && px(i) <= 480), 1);
    end
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(update_done), 0);
    check("rst_score", 32'(score), 0);
    check("rst_x", 32'(plat_x_flat != '0), 0);
    check("rst_y", 32'(plat_y_flat != '0), 0);
    Reset_n = 1;
    @(negedge Clk);

    loadplat = 1;
    @(negedge Clk);
    loadplat = 0;
    walk(40, b, d);
    check("init_busy_cycles", 32'(b), 16);
    check("init_done", 32'(d), 1);
    check_init_layout("init");
    for (int i = 0; i < 16; i++) snap_x[i] = px(i);

    frame_rise(10'h3FB, 1);
    walk(40, b, d);
    exp_score += 5;
    check("s5_busy_cycles", 32'(b), 16);
    check("s5_done", 32'(d), 1);
    check("s5_slot15", 32'(py(15)), 470);
    for (int i = 0; i < 16; i++) begin
      check("s5_y", 32'(py(i)), 32'(20 + 30 * i));
      check("s5_x_kept", 32'(px(i)), 32'(snap_x[i]));
    end
    check("s5_score", 32'(score), sc(exp_score));

    frame_rise(10'h3D8, 1);
    walk(40, b, d);
    exp_score += 15;
    check("s15_done", 32'(d), 1);
    check("s15_respawn_y", 32'(py(15)), 5);
    check("s15_respawn_x", 32'(px(15) >= 32 && px(15) <= 480), 1);
    for (int i = 0; i < 15; i++) check("s15_y", 32'(py(i)), 32'(35 + 30 * i));
    check("s15_x_kept", 32'(px(3)), 32'(snap_x[3]));
    check("s15_score", 32'(score), sc(exp_score));

    frame_rise(10'h3FB, 0);
    walk(30, b, d);
    check("noen_busy", 32'(b), 0);
    check("noen_done", 32'(d), 0);
    check("noen_y", 32'(py(0)), 35);
    frame_rise(10'd3, 1);
    walk(30, b, d);
    check("pos_busy", 32'(b), 0);
    check("pos_done", 32'(d), 0);
    check("pos_y", 32'(py(14)), 455);
    check("pos_score", 32'(score), sc(exp_score));

    frame_rise(10'h3FB, 1);
    wait_busy();
    exp_score += 5;
    walk(5, b, d1);
    check("abort_slot4", 32'(py(4)), 160);
    check("abort_slot5", 32'(py(5)), 185);
    loadplat = 1;
    @(negedge Clk);
    loadplat = 0;
    walk(40, b, d);
    check("abort_busy_cycles", 32'(b), 16);
    check("abort_done_total", 32'(d1 + d), 1);
    check_init_layout("abort");
    check("abort_score", 32'(score), sc(exp_score));

    frame_rise(10'h3FB, 1);
    wait_busy();
    exp_score += 5;
    frame_clk = 0;
    walk(3, b, d1);
    frame_clk = 1;
    walk(40, b, d);
    check("dbl_done_total", 32'(d1 + d), 1);
    check("dbl_score", 32'(score), sc(exp_score));
    check("dbl_slot15", 32'(py(15)), 470);

    frame_rise(10'h3FB, 1);
    wait_busy();
    walk(3, b, d);
    Reset_n = 0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_score", 32'(score), 0);
    check("arst_x", 32'(plat_x_flat != '0), 0);
    check("arst_y", 32'(plat_y_flat != '0), 0);
    check("arst_done", 32'(update_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
